// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC op encoding, fetch FSM states and reset PC.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    localparam word_t RESET_PC_DEF = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_ISSUE = 2'b10,
        ST_HALT  = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: instruction memory handshake plus decode-side issue/retire signals.
interface ifetch_unit_if;
    import cpu_pkg::*;

    logic        imem_req;
    word_t       imem_addr;
    logic        imem_ack;
    word_t       imem_rdata;
    word_t       instr;
    logic        instr_valid;
    logic        instr_ready;
    word_t       pc_out;
    word_t       pc_plus4;
    logic [1:0]  NPCOp;
    word_t       rs_data;
    logic        misalign_err;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc_out, pc_plus4, misalign_err,
        input  imem_ack, imem_rdata, instr_ready, NPCOp, rs_data
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc_out, pc_plus4, misalign_err,
        output imem_ack, imem_rdata, instr_ready, NPCOp, rs_data
    );
endinterface

// File: rtl/ifetch_npc.sv
// Combinational next-PC computation for sequential, branch, jump and register-jump flow.
module ifetch_npc
    import cpu_pkg::*;
(
    input  word_t       pc,
    input  logic [25:0] ir26,
    input  logic [1:0]  npc_op,
    input  word_t       rs_data,
    output word_t       npc
);
    word_t pc4;
    word_t br_off;

    assign pc4    = pc + 32'd4;
    assign br_off = {{14{ir26[15]}}, ir26[15:0], 2'b00};

    always_comb begin
        npc = pc4;
        case (npc_op)
            NPC_PLUS4:  npc = pc4;
            NPC_BRANCH: npc = pc4 + br_off;
            NPC_JUMP:   npc = {pc4[31:28], ir26, 2'b00};
            NPC_JR:     npc = rs_data;
            default:    npc = pc4;
        endcase
    end
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC/IR ownership, imem req/ack fetch, issue to decode, NPC on retire.
// Optional IFETCH_ALIGN_CHK_EN: misaligned NPC sets sticky misalign_err and halts fetch.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_unit_if.master bus
);
    fetch_state_t state, state_nxt;
    word_t        pc_q, pc4_q, ir_q;
    word_t        npc_raw, npc;
    logic         misalign;
    logic         retire;
    logic         req_c, valid_c;

    ifetch_npc u_npc (
        .pc      (pc_q),
        .ir26    (ir_q[25:0]),
        .npc_op  (bus.NPCOp),
        .rs_data (bus.rs_data),
        .npc     (npc)
    );

    assign retire = (state == ST_ISSUE) && bus.instr_ready;

`ifdef IFETCH_ALIGN_CHK_EN
    logic misalign_q;

    assign npc_raw  = npc;
    assign misalign = (npc[1:0] != 2'b00);

    // Sticky until reset; HALT is the only way out of fetch once set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign_q <= 1'b0;
        else if (retire && misalign)
            misalign_q <= 1'b1;
    end

    assign bus.misalign_err = misalign_q;
`else
    assign npc_raw          = npc & 32'hFFFF_FFFC;
    assign misalign         = 1'b0;
    assign bus.misalign_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = ST_FETCH;
            ST_FETCH: if (bus.imem_ack) state_nxt = ST_ISSUE;
            ST_ISSUE: if (bus.instr_ready) state_nxt = misalign ? ST_HALT : ST_FETCH;
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Handshake strobes decoded purely from the state register.
    always_comb begin
        req_c   = 1'b0;
        valid_c = 1'b0;
        case (state)
            ST_FETCH: req_c   = 1'b1;
            ST_ISSUE: valid_c = 1'b1;
            default: begin
                req_c   = 1'b0;
                valid_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            pc4_q <= RESET_PC + 32'd4;
            ir_q  <= '0;
        end else begin
            if ((state == ST_FETCH) && bus.imem_ack)
                ir_q <= bus.imem_rdata;
            if (retire) begin
                pc_q  <= npc_raw;
                pc4_q <= npc_raw + 32'd4;
            end
        end
    end

    assign bus.imem_req    = req_c;
    assign bus.instr_valid = valid_c;
    assign bus.imem_addr   = pc_q;
    assign bus.pc_out      = pc_q;
    assign bus.pc_plus4    = pc4_q;
    assign bus.instr       = ir_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed, table-driven bench for ifetch_unit (PC sequencing, branch/jump/JR, stalls, reset).
module tb_ifetch_unit;
    import cpu_pkg::*;

    typedef struct {
        word_t      ir;
        logic [1:0] op;
        word_t      rs;
        word_t      pc;
        word_t      nxt;
        int         ack_dly;
        int         rdy_dly;
    } vec_t;

    localparam int unsigned NVEC = 17;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [NVEC];

    ifetch_unit_if bus ();

    ifetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One fetch/issue/retire round trip; entered and left with the DUT in FETCH.
    task automatic run_vec(input vec_t v);
        for (int c = 0; c < v.ack_dly; c++) begin
            bus.imem_ack = 1'b0;
            chk("stall_req",   32'(bus.imem_req), 32'd1);
            chk("stall_addr",  bus.imem_addr, v.pc);
            chk("stall_valid", 32'(bus.instr_valid), 32'd0);
            step();
        end
        chk("fetch_req",   32'(bus.imem_req), 32'd1);
        chk("fetch_addr",  bus.imem_addr, v.pc);
        chk("fetch_valid", 32'(bus.instr_valid), 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = v.ir;
        step();
        bus.imem_ack = 1'b0;
        for (int c = 0; c < v.rdy_dly; c++) begin
            chk("hold_valid", 32'(bus.instr_valid), 32'd1);
            chk("hold_instr", bus.instr, v.ir);
            chk("hold_pc",    bus.pc_out, v.pc);
            chk("hold_req",   32'(bus.imem_req), 32'd0);
            bus.imem_ack    = 1'b1;
            bus.imem_rdata  = ~v.ir;
            bus.instr_ready = 1'b0;
            step();
            bus.imem_ack = 1'b0;
        end
        chk("issue_valid", 32'(bus.instr_valid), 32'd1);
        chk("issue_instr", bus.instr, v.ir);
        chk("issue_pc",    bus.pc_out, v.pc);
        chk("issue_pc4",   bus.pc_plus4, v.pc + 32'd4);
        chk("issue_req",   32'(bus.imem_req), 32'd0);
        bus.instr_ready = 1'b1;
        bus.NPCOp       = v.op;
        bus.rs_data     = v.rs;
        step();
        bus.instr_ready = 1'b0;
        bus.NPCOp       = NPC_JR;
        bus.rs_data     = 32'hDEAD_BEE0;
        chk("next_req",   32'(bus.imem_req), 32'd1);
        chk("next_addr",  bus.imem_addr, v.nxt);
        chk("next_valid", 32'(bus.instr_valid), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{32'h2400_0000, NPC_PLUS4,  32'h0,         32'h0000_3000, 32'h0000_3004, 0, 0};
        vecs[1]  = '{32'h2400_0001, NPC_PLUS4,  32'h0,         32'h0000_3004, 32'h0000_3008, 0, 0};
        vecs[2]  = '{32'h2400_0002, NPC_PLUS4,  32'h0,         32'h0000_3008, 32'h0000_300C, 5, 0};
        vecs[3]  = '{32'h2400_0003, NPC_PLUS4,  32'h0,         32'h0000_300C, 32'h0000_3010, 0, 4};
        vecs[4]  = '{32'h1000_FFFC, NPC_BRANCH, 32'h0,         32'h0000_3010, 32'h0000_3004, 0, 0};
        vecs[5]  = '{32'h0000_0008, NPC_JR,     32'h0000_3010, 32'h0000_3004, 32'h0000_3010, 0, 0};
        vecs[6]  = '{32'h1000_0003, NPC_BRANCH, 32'h0,         32'h0000_3010, 32'h0000_3020, 0, 0};
        vecs[7]  = '{32'h0000_0008, NPC_JR,     32'h0000_3000, 32'h0000_3020, 32'h0000_3000, 0, 0};
        vecs[8]  = '{32'h0800_0C10, NPC_JUMP,   32'h0,         32'h0000_3000, 32'h0000_3040, 0, 0};
        vecs[9]  = '{32'h0000_0008, NPC_JR,     32'h0000_3100, 32'h0000_3040, 32'h0000_3100, 0, 0};
        vecs[10] = '{32'h0BFF_FFFF, NPC_JUMP,   32'h0,         32'h0000_3100, 32'h0FFF_FFFC, 0, 0};
        vecs[11] = '{32'h0000_0000, NPC_PLUS4,  32'h0,         32'h0FFF_FFFC, 32'h1000_0000, 0, 0};
        vecs[12] = '{32'h1000_FFFF, NPC_BRANCH, 32'h0,         32'h1000_0000, 32'h1000_0000, 0, 0};
        vecs[13] = '{32'h0C00_0001, NPC_JUMP,   32'h0,         32'h1000_0000, 32'h1000_0004, 0, 0};
        vecs[14] = '{32'h0000_0008, NPC_JR,     32'hFFFF_FFFC, 32'h1000_0004, 32'hFFFF_FFFC, 0, 0};
        vecs[15] = '{32'h0000_0000, NPC_PLUS4,  32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 0, 0};
        vecs[16] = '{32'h0000_0008, NPC_JR,     32'h0000_3000, 32'h0000_0000, 32'h0000_3000, 1, 2};

        rst             = 1'b1;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        bus.NPCOp       = NPC_PLUS4;
        bus.rs_data     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req",      32'(bus.imem_req), 32'd0);
        chk("rst_valid",    32'(bus.instr_valid), 32'd0);
        chk("rst_addr",     bus.imem_addr, 32'h0000_3000);
        chk("rst_pc",       bus.pc_out, 32'h0000_3000);
        chk("rst_pc4",      bus.pc_plus4, 32'h0000_3004);
        chk("rst_instr",    bus.instr, 32'h0);
        chk("rst_misalign", 32'(bus.misalign_err), 32'd0);
        rst = 1'b0;
        chk("idle_req", 32'(bus.imem_req), 32'd0);
        step();

        for (int i = 0; i < int'(NVEC); i++)
            run_vec(vecs[i]);

        // Reset during FETCH: request drops without waiting for a clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req",  32'(bus.imem_req), 32'd0);
        chk("arst_addr", bus.imem_addr, 32'h0000_3000);
        step();
        rst            = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hCAFE_F00D;
        chk("arst_instr", bus.instr, 32'h0);
        chk("arst_idle",  32'(bus.imem_req), 32'd0);
        step();
        bus.imem_ack = 1'b0;
        chk("refetch_req",   32'(bus.imem_req), 32'd1);
        chk("refetch_addr",  bus.imem_addr, 32'h0000_3000);
        chk("refetch_instr", bus.instr, 32'h0);

        // Misaligned JR target.
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0000_0008;
        step();
        bus.imem_ack    = 1'b0;
        chk("jr_valid", 32'(bus.instr_valid), 32'd1);
        bus.instr_ready = 1'b1;
        bus.NPCOp       = NPC_JR;
        bus.rs_data     = 32'h0000_3102;
        step();
        bus.instr_ready = 1'b0;
`ifdef IFETCH_ALIGN_CHK_EN
        chk("mis_err", 32'(bus.misalign_err), 32'd1);
        chk("mis_pc",  bus.pc_out, 32'h0000_3102);
        for (int c = 0; c < 3; c++) begin
            chk("halt_req",   32'(bus.imem_req), 32'd0);
            chk("halt_valid", 32'(bus.instr_valid), 32'd0);
            chk("halt_err",   32'(bus.misalign_err), 32'd1);
            bus.imem_ack    = 1'b1;
            bus.instr_ready = 1'b1;
            step();
        end
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b0;
`else
        chk("mis_err",  32'(bus.misalign_err), 32'd0);
        chk("mis_addr", bus.imem_addr, 32'h0000_3100);
        chk("mis_req",  32'(bus.imem_req), 32'd1);
        chk("mis_pc4",  bus.pc_plus4, 32'h0000_3104);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
